// File: rtl/afifo_burst_reader_pkg.sv
// Shared definitions for the async-FIFO burst reader.
//   rd_state_t : burst controller states (IDLE / BURST / DRAIN)
package afifo_burst_reader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DRAIN = 2'd2
   } rd_state_t;

endpackage

// File: rtl/afifo_burst_reader_if.sv
// FIFO read port plus the outgoing valid/ready stream of the burst reader.
//   master : the burst reader (drives fifo_rd_en and the stream)
//   slave  : the FIFO/consumer side
//   fifo_empty, fifo_rd_data, fifo_rd_en : FIFO read port (RD_FAST mode)
//   out_valid, out_data, out_last, out_ready : output stream
interface afifo_burst_reader_if #(
   parameter int unsigned W = 8
);
   logic         fifo_empty;
   logic [W-1:0] fifo_rd_data;
   logic         fifo_rd_en;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         out_last;
   logic         out_ready;

   modport master (
      input  fifo_empty, fifo_rd_data, out_ready,
      output fifo_rd_en, out_valid, out_data, out_last
   );

   modport slave (
      output fifo_empty, fifo_rd_data, out_ready,
      input  fifo_rd_en, out_valid, out_data, out_last
   );
endinterface

// File: rtl/afifo_rd_skid.sv
// Two-entry register buffer between the FIFO pop and the output stream.
//   rd_clk, rd_reset_n : clock, async active-low reset (to empty)
//   clr                : synchronous clear to empty
//   wr_en, wr_data     : push a word (caller guarantees room, or a same-cycle read)
//   rd_en              : pop the head word (ignored when empty)
//   rd_data            : head word (entry 0)
//   cnt                : occupancy 0..2
module afifo_rd_skid #(
   parameter int unsigned DW = 9
) (
   input  logic          rd_clk,
   input  logic          rd_reset_n,
   input  logic          clr,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   output logic [DW-1:0] rd_data,
   output logic [1:0]    cnt
);
   logic [DW-1:0] ent0;
   logic [DW-1:0] ent1;
   logic          pop;

   assign pop     = rd_en && (cnt != 2'd0);
   assign rd_data = ent0;

   always_ff @(posedge rd_clk or negedge rd_reset_n) begin
      if (!rd_reset_n) begin
         ent0 <= '0;
         ent1 <= '0;
         cnt  <= '0;
      end else if (clr) begin
         ent0 <= '0;
         ent1 <= '0;
         cnt  <= '0;
      end else if (wr_en && pop) begin
         // occupancy unchanged: the new word lands behind whatever stays
         if (cnt == 2'd1) begin
            ent0 <= wr_data;
         end else begin
            ent0 <= ent1;
            ent1 <= wr_data;
         end
      end else if (wr_en) begin
         if (cnt == 2'd0) ent0 <= wr_data;
         else             ent1 <= wr_data;
         cnt <= cnt + 2'd1;
      end else if (pop) begin
         ent0 <= ent1;
         cnt  <= cnt - 2'd1;
      end
   end
endmodule

// File: rtl/afifo_burst_reader.sv
// Read-side drain controller: accepts a burst request, pops exactly
// req_len+1 words from the FIFO without underflow and presents them as a
// registered valid/ready stream with the final word tagged out_last.
//   rd_clk, rd_reset_n : clock, async active-low reset
//   req, req_len       : burst request (level) and word count minus 1
//   req_ack            : 1-cycle pulse when the request is accepted
//   busy               : burst in progress
//   flush              : synchronous abort, highest priority
//   done               : 1-cycle pulse after the last word is accepted
//   bus                : FIFO read port and output stream (master side)
module afifo_burst_reader
   import afifo_burst_reader_pkg::*;
#(
   parameter int unsigned W    = 8,
   parameter int unsigned BL_W = 4
) (
   input  logic            rd_clk,
   input  logic            rd_reset_n,
   input  logic            req,
   input  logic [BL_W-1:0] req_len,
   output logic            req_ack,
   output logic            busy,
   input  logic            flush,
   output logic            done,
   afifo_burst_reader_if.master bus
);
   rd_state_t       state;
   logic [BL_W-1:0] remain;
   logic [1:0]      buf_cnt;
   logic [W:0]      buf_head;
   logic            pop;
   logic            consume;

   // Pop gating uses only registered state plus the FIFO flag and flush,
   // so out_ready never reaches fifo_rd_en combinationally.
   assign pop            = (state == BURST) && !bus.fifo_empty && (buf_cnt < 2'd2) && !flush;
   assign bus.fifo_rd_en = pop;
   assign busy           = (state != IDLE);

   assign bus.out_valid  = (buf_cnt != 2'd0);
   assign bus.out_last   = buf_head[W];
   assign bus.out_data   = buf_head[W-1:0];
   assign consume        = bus.out_valid && bus.out_ready;

   afifo_rd_skid #(.DW(W + 1)) u_skid (
      .rd_clk     (rd_clk),
      .rd_reset_n (rd_reset_n),
      .clr        (flush),
      .wr_en      (pop),
      .wr_data    ({(remain == '0), bus.fifo_rd_data}),
      .rd_en      (consume),
      .rd_data    (buf_head),
      .cnt        (buf_cnt)
   );

   always_ff @(posedge rd_clk or negedge rd_reset_n) begin
      if (!rd_reset_n) begin
         state   <= IDLE;
         remain  <= '0;
         req_ack <= 1'b0;
         done    <= 1'b0;
      end else begin
         req_ack <= 1'b0;
         done    <= 1'b0;
         if (flush) begin
            state <= IDLE;
         end else begin
            unique case (state)
               IDLE: begin
                  if (req) begin
                     req_ack <= 1'b1;
                     remain  <= req_len;
                     state   <= BURST;
                  end
               end
               BURST: begin
                  if (pop) begin
                     if (remain == '0) state  <= DRAIN;
                     else              remain <= remain - 1'b1;
                  end
               end
               DRAIN: begin
                  if (consume && bus.out_last) begin
                     done  <= 1'b1;
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_afifo_burst_reader.sv
module tb_afifo_burst_reader;
   logic       rd_clk = 1'b0;
   logic       rd_reset_n = 1'b0;
   logic       req = 1'b0;
   logic [3:0] req_len = '0;
   logic       req_ack;
   logic       busy;
   logic       flush = 1'b0;
   logic       done;

   afifo_burst_reader_if #(.W(8)) bus ();

   afifo_burst_reader #(.W(8), .BL_W(4)) dut (
      .rd_clk     (rd_clk),
      .rd_reset_n (rd_reset_n),
      .req        (req),
      .req_len    (req_len),
      .req_ack    (req_ack),
      .busy       (busy),
      .flush      (flush),
      .done       (done),
      .bus        (bus.master)
   );

   always #5 rd_clk = ~rd_clk;

   // FIFO model in RD_FAST mode: head word combinational, pop on rd_en.
   logic [7:0] mem [0:63];
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   assign bus.fifo_empty   = (rd_ptr == wr_ptr);
   assign bus.fifo_rd_data = mem[rd_ptr % 64];
   always @(posedge rd_clk)
      if (bus.fifo_rd_en && !bus.fifo_empty) rd_ptr <= rd_ptr + 1;

   int cyc = 0;
   always @(posedge rd_clk) cyc <= cyc + 1;

   // Event recorders, sampled on the falling edge.
   logic [8:0] got_w [0:63];
   int         got_c [0:63];
   int         got_n = 0;
   int         done_c [0:15];
   int         done_n = 0;
   int         ack_c [0:15];
   int         ack_n = 0;
   int         viol = 0;
   always @(negedge rd_clk) begin
      if (bus.out_valid && bus.out_ready && got_n < 64) begin
         got_w[got_n] = {bus.out_last, bus.out_data};
         got_c[got_n] = cyc;
         got_n++;
      end
      if (done && done_n < 16) begin
         done_c[done_n] = cyc;
         done_n++;
      end
      if (req_ack && ack_n < 16) begin
         ack_c[ack_n] = cyc;
         ack_n++;
      end
      if (bus.fifo_rd_en && bus.fifo_empty) viol++;
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge rd_clk);
         #1;
      end
   endtask

   task automatic put(input logic [7:0] d);
      mem[wr_ptr % 64] = d;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic start(input logic [3:0] len);
      int k;
      k = 0;
      req = 1'b1;
      req_len = len;
      while (!req_ack && k < 20) begin
         tick();
         k++;
      end
      if (k >= 20) chk("ack_timeout", 0, 1);
      req = 1'b0;
   endtask

   task automatic wait_done(input int base);
      int k;
      k = 0;
      while (done_n == base && k < 200) begin
         tick();
         k++;
      end
      if (k >= 200) chk("done_timeout", 0, 1);
   endtask

   initial begin
      int gb, db, ab, rp0, k;
      bus.out_ready = 1'b0;

      // reset state
      tick(2);
      chk("reset_outs", {req_ack, busy, bus.fifo_rd_en, bus.out_valid, bus.out_last, done, bus.out_data}, 0);
      rd_reset_n = 1'b1;
      tick();

      // 1: 4-word burst, free-running consumer
      bus.out_ready = 1'b1;
      put(8'hA1); put(8'hA2); put(8'hA3); put(8'hA4);
      gb = got_n; db = done_n; ab = ack_n;
      start(4'd3);
      wait_done(db);
      tick();
      chk("t1_cnt", got_n - gb, 4);
      chk("t1_w0", got_w[gb],   {1'b0, 8'hA1});
      chk("t1_w1", got_w[gb+1], {1'b0, 8'hA2});
      chk("t1_w2", got_w[gb+2], {1'b0, 8'hA3});
      chk("t1_w3", got_w[gb+3], {1'b1, 8'hA4});
      chk("t1_lat", got_c[gb] - ack_c[ab], 1);
      chk("t1_rate", got_c[gb+3] - got_c[gb], 3);
      chk("t1_done", done_c[db] - got_c[gb+3], 1);
      chk("t1_idle", busy, 0);

      // 2: FIFO runs dry mid-burst
      put(8'hB1); put(8'hB2);
      gb = got_n; db = done_n; rp0 = rd_ptr;
      start(4'd3);
      tick(5);
      chk("t2_pops", rd_ptr - rp0, 2);
      chk("t2_busy", busy, 1);
      chk("t2_valid", bus.out_valid, 0);
      put(8'hB3); put(8'hB4);
      wait_done(db);
      chk("t2_cnt", got_n - gb, 4);
      chk("t2_w0", got_w[gb],   {1'b0, 8'hB1});
      chk("t2_w1", got_w[gb+1], {1'b0, 8'hB2});
      chk("t2_w2", got_w[gb+2], {1'b0, 8'hB3});
      chk("t2_w3", got_w[gb+3], {1'b1, 8'hB4});
      tick();

      // 3: back-pressure fills the buffer
      bus.out_ready = 1'b0;
      for (int i = 0; i < 8; i++) put(8'h30 + 8'(i));
      gb = got_n; db = done_n; rp0 = rd_ptr;
      start(4'd7);
      tick(6);
      chk("t3_pops", rd_ptr - rp0, 2);
      chk("t3_rden", bus.fifo_rd_en, 0);
      chk("t3_hold0", {bus.out_valid, bus.out_data}, {1'b1, 8'h30});
      tick(3);
      chk("t3_hold1", {bus.out_valid, bus.out_last, bus.out_data}, {2'b10, 8'h30});
      bus.out_ready = 1'b1;
      wait_done(db);
      chk("t3_cnt", got_n - gb, 8);
      for (int i = 0; i < 8; i++)
         chk($sformatf("t3_w%0d", i), got_w[gb+i], {(i == 7), 8'h30 + 8'(i)});
      tick();

      // 4: flush after the second pop of a 5-word burst
      put(8'hC1); put(8'hC2); put(8'hC3); put(8'hC4); put(8'hC5);
      gb = got_n; db = done_n; rp0 = rd_ptr;
      start(4'd4);
      k = 0;
      while ((rd_ptr - rp0) < 2 && k < 20) begin
         tick();
         k++;
      end
      if (k >= 20) chk("t4_timeout", 0, 1);
      flush = 1'b1;
      #1;
      chk("t4_rden_flush", bus.fifo_rd_en, 0);
      tick();
      flush = 1'b0;
      chk("t4_after", {bus.out_valid, busy}, 0);
      tick(4);
      chk("t4_nodone", done_n - db, 0);
      chk("t4_left", wr_ptr - rd_ptr, 3);
      chk("t4_cnt", got_n - gb, 2);
      gb = got_n; db = done_n;
      start(4'd2);
      wait_done(db);
      chk("t4_cnt2", got_n - gb, 3);
      chk("t4_w0", got_w[gb],   {1'b0, 8'hC3});
      chk("t4_w1", got_w[gb+1], {1'b0, 8'hC4});
      chk("t4_w2", got_w[gb+2], {1'b1, 8'hC5});
      tick();

      // 5: req held across two single-word bursts
      put(8'hD1); put(8'hD2);
      gb = got_n; db = done_n; ab = ack_n;
      req_len = 4'd0;
      req = 1'b1;
      k = 0;
      while (ack_n < ab + 2 && k < 30) begin
         tick();
         k++;
      end
      if (k >= 30) chk("t5_timeout", 0, 1);
      req = 1'b0;
      wait_done(db + 1);
      tick(3);
      chk("t5_acks", ack_n - ab, 2);
      chk("t5_ack_gap", ack_c[ab+1] - ack_c[ab], 3);
      chk("t5_dones", done_n - db, 2);
      chk("t5_w0", got_w[gb],   {1'b1, 8'hD1});
      chk("t5_w1", got_w[gb+1], {1'b1, 8'hD2});

      // 6: async reset in DRAIN with a full buffer
      bus.out_ready = 1'b0;
      put(8'hE1); put(8'hE2);
      rp0 = rd_ptr;
      start(4'd1);
      tick(2);
      chk("t6_pre", {busy, bus.out_valid, 2'(rd_ptr - rp0)}, 4'b1110);
      rd_reset_n = 1'b0;
      #1;
      chk("t6_reset", {req_ack, busy, bus.fifo_rd_en, bus.out_valid, bus.out_last, done, bus.out_data}, 0);
      tick(2);
      rd_reset_n = 1'b1;
      tick();
      bus.out_ready = 1'b1;
      put(8'hE3);
      gb = got_n; db = done_n;
      start(4'd0);
      wait_done(db);
      chk("t6_cnt", got_n - gb, 1);
      chk("t6_w0", got_w[gb], {1'b1, 8'hE3});

      chk("rd_en_while_empty", viol, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
